mem_arbiter: RTL

Single-port memory arbiter shared by the instruction-fetch and MEM pipeline stages of the RV64 core. It grants one of the two requesters at a time, with the data (MEM) side taking priority. It runs one transaction on the shared bus, returns the response to the granted stage and raises `stall_req` to the pipeline controller while any request is pending. It also handles fetch cancellation on redirect and bus timeouts.

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: pipeline-side and bus-side signals of the fetch/data memory arbiter
//   slave  : arbiter view (takes IF/MEM requests and bus responses, drives ready/data and the bus request)
//   master : environment view (pipeline stages and memory bus)
interface mem_arbiter_if;
    logic        if_req_valid;
    logic [63:0] if_addr;
    logic        flush_if;
    logic        if_ready;
    logic [31:0] if_inst;
    logic        if_err;
    logic        mem_req_valid;
    logic        mem_rw;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        mem_err;
    logic        bus_valid;
    logic        bus_rw;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wmask;
    logic        bus_accept;
    logic        bus_resp_valid;
    logic [63:0] bus_rdata;
    logic        stall_req;

    modport slave (
        input  if_req_valid, if_addr, flush_if, mem_req_valid, mem_rw, mem_addr, mem_wdata, mem_wmask,
               bus_accept, bus_resp_valid, bus_rdata,
        output if_ready, if_inst, if_err, mem_ready, mem_rdata, mem_err,
               bus_valid, bus_rw, bus_addr, bus_wdata, bus_wmask, stall_req
    );

    modport master (
        output if_req_valid, if_addr, flush_if, mem_req_valid, mem_rw, mem_addr, mem_wdata, mem_wmask,
               bus_accept, bus_resp_valid, bus_rdata,
        input  if_ready, if_inst, if_err, mem_ready, mem_rdata, mem_err,
               bus_valid, bus_rw, bus_addr, bus_wdata, bus_wmask, stall_req
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter for IF and MEM stages, MEM has priority
//   clk : clock, rising edge
//   rst : synchronous reset, active low
//   a   : mem_arbiter_if.slave (requests, ready/data responses, bus request/response, stall_req)
//   BUS_TIMEOUT : cycles waited for a bus response before completing with error
module mem_arbiter #(
    parameter int BUS_TIMEOUT = 255
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave a
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        own_mem_q, own_mem_d;
    logic        drop_q, drop_d;
    logic        bus_valid_q, bus_valid_d;
    logic        bus_rw_q, bus_rw_d;
    logic [63:0] bus_addr_q, bus_addr_d;
    logic [63:0] bus_wdata_q, bus_wdata_d;
    logic [7:0]  bus_wmask_q, bus_wmask_d;
    logic        if_ready_q, if_ready_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_err_q, if_err_d;
    logic        mem_ready_q, mem_ready_d;
    logic [63:0] mem_rdata_q, mem_rdata_d;
    logic        mem_err_q, mem_err_d;
    logic        done;
    logic [63:0] rsp_data;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        own_mem_d   = own_mem_q;
        // a redirect while a fetch is in flight discards its result
        drop_d      = drop_q | (~own_mem_q & a.flush_if & (state_q != IDLE));
        bus_valid_d = bus_valid_q;
        bus_rw_d    = bus_rw_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wmask_d = bus_wmask_q;
        case (state_q)
            IDLE: if (a.mem_req_valid | (a.if_req_valid & ~a.flush_if)) begin
                state_d     = REQ;
                own_mem_d   = a.mem_req_valid;
                drop_d      = 1'b0;
                bus_valid_d = 1'b1;
                bus_rw_d    = a.mem_req_valid & a.mem_rw;
                bus_addr_d  = a.mem_req_valid ? a.mem_addr : a.if_addr;
                bus_wdata_d = a.mem_req_valid ? a.mem_wdata : '0;
                bus_wmask_d = a.mem_req_valid ? a.mem_wmask : '0;
            end
            REQ: if (a.bus_accept) begin
                state_d     = WAIT;
                cnt_d       = '0;
                bus_valid_d = 1'b0;
            end
            WAIT: if (a.bus_resp_valid | (cnt_q == 16'(BUS_TIMEOUT)))
                state_d = DONE;
            else
                cnt_d = cnt_q + 16'd1;
            default: state_d = IDLE;
        endcase
        // ready/data are registered on entry to DONE so they appear exactly in the DONE cycle
        done        = (state_q == WAIT) & (state_d == DONE);
        rsp_data    = a.bus_resp_valid ? a.bus_rdata : '0;
        mem_ready_d = done & own_mem_q;
        mem_rdata_d = (mem_ready_d & ~bus_rw_q) ? rsp_data : '0;
        mem_err_d   = mem_ready_d & ~a.bus_resp_valid;
        if_ready_d  = done & ~own_mem_q & ~drop_d;
        if_inst_d   = if_ready_d ? rsp_data[31:0] : '0;
        if_err_d    = if_ready_d & ~a.bus_resp_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            own_mem_q   <= 1'b0;
            drop_q      <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_rw_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
            if_ready_q  <= 1'b0;
            if_inst_q   <= '0;
            if_err_q    <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            own_mem_q   <= own_mem_d;
            drop_q      <= drop_d;
            bus_valid_q <= bus_valid_d;
            bus_rw_q    <= bus_rw_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wmask_q <= bus_wmask_d;
            if_ready_q  <= if_ready_d;
            if_inst_q   <= if_inst_d;
            if_err_q    <= if_err_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign a.bus_valid = bus_valid_q;
    assign a.bus_rw    = bus_rw_q;
    assign a.bus_addr  = bus_addr_q;
    assign a.bus_wdata = bus_wdata_q;
    assign a.bus_wmask = bus_wmask_q;
    assign a.if_ready  = if_ready_q;
    assign a.if_inst   = if_inst_q;
    assign a.if_err    = if_err_q;
    assign a.mem_ready = mem_ready_q;
    assign a.mem_rdata = mem_rdata_q;
    assign a.mem_err   = mem_err_q;
    assign a.stall_req = rst & ((a.mem_req_valid & ~mem_ready_q) | (a.if_req_valid & ~if_ready_q & ~a.flush_if));
endmodule
